// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating-counter direction prediction
module branch_target_predictor #(
    parameter int ADDRESS_LEN = 12,
    parameter int INDEX_BITS  = 4,
    parameter int CTR_BITS    = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [ADDRESS_LEN-1:0] lookup_pc,
    output logic                   pred_hit,
    output logic                   pred_taken,
    output logic [ADDRESS_LEN-1:0] pred_next_pc,
    input  logic                   res_valid,
    input  logic [ADDRESS_LEN-1:0] res_pc,
    input  logic                   res_taken,
    input  logic [ADDRESS_LEN-1:0] res_target,
    input  logic                   res_pred_taken,
    input  logic [ADDRESS_LEN-1:0] res_pred_target,
    output logic                   mispredict,
    output logic [ADDRESS_LEN-1:0] redirect_pc,
    output logic [CNT_BITS-1:0]    resolve_count,
    output logic [CNT_BITS-1:0]    mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDRESS_LEN - INDEX_BITS;
    localparam logic [CTR_BITS-1:0]    CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0]    CTR_WT   = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0]    CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]    CTR_ONE  = 1;
    localparam logic [CNT_BITS-1:0]    CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]    CNT_ONE  = 1;
    localparam logic [ADDRESS_LEN-1:0] PC_ONE   = 1;

    logic                   valid_q  [ENTRIES];
    logic [TAG_W-1:0]       tag_q    [ENTRIES];
    logic [ADDRESS_LEN-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0]    ctr_q    [ENTRIES];
    logic [CNT_BITS-1:0]    resolve_count_q, mispredict_count_q;

    logic [INDEX_BITS-1:0]  lk_idx, rs_idx;
    logic [TAG_W-1:0]       lk_tag, rs_tag;
    logic                   rs_hit, wr_en_d;
    logic [CTR_BITS-1:0]    rs_ctr, wr_ctr_d;
    logic [ADDRESS_LEN-1:0] wr_target_d;

    assign lk_idx = lookup_pc[INDEX_BITS-1:0];
    assign lk_tag = lookup_pc[ADDRESS_LEN-1:INDEX_BITS];
    assign rs_idx = res_pc[INDEX_BITS-1:0];
    assign rs_tag = res_pc[ADDRESS_LEN-1:INDEX_BITS];

    // Fetch-side lookup: tag match on the indexed entry, direction from counter MSB
    always_comb begin
        pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
        pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + PC_ONE;
    end

    // Execute-side mispredict detection and corrected fetch address
    always_comb begin
        mispredict  = res_valid && ((res_taken != res_pred_taken) ||
                      (res_taken && (res_target != res_pred_target)));
        redirect_pc = res_taken ? res_target : res_pc + PC_ONE;
    end

    // Next contents of the resolved entry: saturating counter step or fresh allocation
    always_comb begin
        rs_hit      = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
        rs_ctr      = ctr_q[rs_idx];
        wr_en_d     = res_valid && !flush && (res_taken || rs_hit);
        wr_ctr_d    = !rs_hit ? CTR_WT :
                      res_taken ? ((rs_ctr == CTR_MAX) ? rs_ctr : rs_ctr + CTR_ONE) :
                      ((rs_ctr == '0) ? rs_ctr : rs_ctr - CTR_ONE);
        wr_target_d = res_taken ? res_target : target_q[rs_idx];
    end

    // Table storage: reset/flush clear every entry, otherwise write the resolved entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (wr_en_d) begin
            valid_q[rs_idx]  <= 1'b1;
            tag_q[rs_idx]    <= rs_tag;
            target_q[rs_idx] <= wr_target_d;
            ctr_q[rs_idx]    <= wr_ctr_d;
        end
    end

    // Saturating statistics counters; flush outranks a same-cycle resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resolve_count_q    <= '0;
            mispredict_count_q <= '0;
        end else if (flush) begin
            resolve_count_q    <= '0;
            mispredict_count_q <= '0;
        end else if (res_valid) begin
            if (resolve_count_q != CNT_MAX) resolve_count_q <= resolve_count_q + CNT_ONE;
            if (mispredict && mispredict_count_q != CNT_MAX)
                mispredict_count_q <= mispredict_count_q + CNT_ONE;
        end
    end

    assign resolve_count    = resolve_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed scoreboard bench for the branch predictor/BTB
module tb_branch_target_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [11:0] lookup_pc = '0;
    logic        pred_hit, pred_taken;
    logic [11:0] pred_next_pc;
    logic        res_valid = 1'b0;
    logic [11:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [11:0] res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic [11:0] res_pred_target = '0;
    logic        mispredict;
    logic [11:0] redirect_pc;
    logic [15:0] resolve_count, mispredict_count;
    logic        s_hit, s_taken, s_misp;
    logic [11:0] s_next, s_redir;
    logic [1:0]  s_rcnt, s_mcnt;

    int tests = 0;
    int fails = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    branch_target_predictor #(.ADDRESS_LEN(12), .INDEX_BITS(4), .CTR_BITS(2), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .resolve_count(resolve_count), .mispredict_count(mispredict_count)
    );

    branch_target_predictor #(.ADDRESS_LEN(12), .INDEX_BITS(4), .CTR_BITS(2), .CNT_BITS(2)) sat (
        .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_next_pc(s_next),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(s_misp), .redirect_pc(s_redir),
        .resolve_count(s_rcnt), .mispredict_count(s_mcnt)
    );

    task automatic expect_v(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %0h required nothing queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %0h required %0h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic [11:0] pc, input logic tk, input logic [11:0] tgt,
                             input logic ptk, input logic [11:0] ptgt);
        res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
        res_pred_taken = ptk; res_pred_target = ptgt;
    endtask

    task automatic look(input string t, input logic [11:0] pc, input logic hit,
                        input logic tk, input logic [11:0] nxt);
        lookup_pc = pc;
        expect_v({t, "_hit"}, 32'(hit));
        expect_v({t, "_taken"}, 32'(tk));
        expect_v({t, "_next"}, 32'(nxt));
        #1;
        observe(32'(pred_hit));
        observe(32'(pred_taken));
        observe(32'(pred_next_pc));
    endtask

    task automatic counts(input string t, input int r, input int m);
        expect_v({t, "_resolve_count"}, 32'(r));
        expect_v({t, "_mispredict_count"}, 32'(m));
        observe(32'(resolve_count));
        observe(32'(mispredict_count));
    endtask

    task automatic misp(input string t, input logic m, input logic [11:0] rpc);
        expect_v({t, "_mispredict"}, 32'(m));
        #1;
        observe(32'(mispredict));
        if (m) begin
            expect_v({t, "_redirect"}, 32'(rpc));
            observe(32'(redirect_pc));
        end
    endtask

    initial begin
        #2;
        look("rst_020", 12'h020, 1'b0, 1'b0, 12'h021);
        look("rst_fff", 12'hFFF, 1'b0, 1'b0, 12'h000);
        counts("rst", 0, 0);
        misp("rst_idle", 1'b0, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        tick();
        drive_res(12'h023, 1'b1, 12'h100, 1'b0, 12'h024);
        misp("alloc", 1'b1, 12'h100);
        look("no_bypass", 12'h023, 1'b0, 1'b0, 12'h024);
        tick();
        res_valid = 1'b0;
        look("alloc_hit", 12'h023, 1'b1, 1'b1, 12'h100);
        counts("alloc", 1, 1);
        expect_v("sat_cnt_first", 32'(1));
        observe(32'(s_rcnt));
        for (int i = 0; i < 3; i++) begin
            drive_res(12'h023, 1'b1, 12'h100, 1'b1, 12'h100);
            misp("taken_ok", 1'b0, 12'h000);
            tick();
        end
        res_valid = 1'b0;
        look("ctr_max", 12'h023, 1'b1, 1'b1, 12'h100);
        drive_res(12'h023, 1'b0, 12'h777, 1'b1, 12'h100);
        misp("nt1", 1'b1, 12'h024);
        tick();
        res_valid = 1'b0;
        look("nt1_state", 12'h023, 1'b1, 1'b1, 12'h100);
        drive_res(12'h023, 1'b0, 12'h777, 1'b1, 12'h100);
        misp("nt2", 1'b1, 12'h024);
        tick();
        res_valid = 1'b0;
        look("nt2_state", 12'h023, 1'b1, 1'b0, 12'h024);
        drive_res(12'h023, 1'b0, 12'h777, 1'b0, 12'h024);
        misp("nt3", 1'b0, 12'h000);
        tick();
        drive_res(12'h023, 1'b1, 12'h100, 1'b0, 12'h024);
        misp("floor_taken", 1'b1, 12'h100);
        tick();
        res_valid = 1'b0;
        look("ctr_floor", 12'h023, 1'b1, 1'b0, 12'h024);
        counts("sat_seq", 8, 4);
        expect_v("sat_resolve", 32'(3));
        expect_v("sat_mispredict", 32'(3));
        observe(32'(s_rcnt));
        observe(32'(s_mcnt));
        drive_res(12'h033, 1'b1, 12'h150, 1'b0, 12'h034);
        misp("alias", 1'b1, 12'h150);
        tick();
        drive_res(12'h067, 1'b0, 12'h300, 1'b0, 12'h068);
        misp("miss_nt", 1'b0, 12'h000);
        tick();
        res_valid = 1'b0;
        look("alias_old", 12'h023, 1'b0, 1'b0, 12'h024);
        look("alias_new", 12'h033, 1'b1, 1'b1, 12'h150);
        look("miss_nt", 12'h067, 1'b0, 1'b0, 12'h068);
        drive_res(12'h033, 1'b1, 12'h200, 1'b1, 12'h100);
        misp("tgt_change", 1'b1, 12'h200);
        tick();
        res_valid = 1'b0;
        look("tgt_change", 12'h033, 1'b1, 1'b1, 12'h200);
        counts("tgt_change", 11, 6);
        flush = 1'b1;
        drive_res(12'h045, 1'b1, 12'h300, 1'b0, 12'h046);
        misp("flush", 1'b1, 12'h300);
        tick();
        flush = 1'b0;
        res_valid = 1'b0;
        look("flush_045", 12'h045, 1'b0, 1'b0, 12'h046);
        look("flush_033", 12'h033, 1'b0, 1'b0, 12'h034);
        counts("flush", 0, 0);
        expect_v("flush_sat", 32'(0));
        observe(32'(s_rcnt));
        drive_res(12'h033, 1'b1, 12'h2A0, 1'b0, 12'h034);
        tick();
        res_valid = 1'b0;
        look("realloc", 12'h033, 1'b1, 1'b1, 12'h2A0);
        counts("realloc", 1, 1);
        drive_res(12'h055, 1'b1, 12'h111, 1'b0, 12'h056);
        rst = 1'b0;
        misp("rst_mid", 1'b1, 12'h111);
        look("rst_mid", 12'h033, 1'b0, 1'b0, 12'h034);
        counts("rst_mid", 0, 0);
        res_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_res(12'h055, 1'b1, 12'h3A0, 1'b0, 12'h056);
        tick();
        res_valid = 1'b0;
        look("post_rst", 12'h055, 1'b1, 1'b1, 12'h3A0);
        counts("post_rst", 1, 1);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_leftover: observed %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
